// File: rtl/ysyx_22050019_mem_rd_arbiter.sv
// ysyx_22050019_mem_rd_arbiter: round-robin arbiter that merges icache and dcache
// single-beat reads onto one shared memory read port, one transaction at a time.
`default_nettype none

module ysyx_22050019_mem_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_ar_valid_i,
    output logic                  i_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] i_ar_addr_i,
    output logic                  i_r_valid_o,
    input  logic                  i_r_ready_i,
    output logic [DATA_WIDTH-1:0] i_r_data_o,
    output logic [1:0]            i_r_resp_o,

    input  logic                  d_ar_valid_i,
    output logic                  d_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] d_ar_addr_i,
    output logic                  d_r_valid_o,
    input  logic                  d_r_ready_i,
    output logic [DATA_WIDTH-1:0] d_r_data_o,
    output logic [1:0]            d_r_resp_o,

    output logic                  mem_ar_valid_o,
    input  logic                  mem_ar_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_ar_addr_o,
    input  logic                  mem_r_valid_i,
    output logic                  mem_r_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_r_data_i,
    input  logic [1:0]            mem_r_resp_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;   // 0 = icache, 1 = dcache
    logic   last, last_nxt;     // owner of the last completed transaction
    logic   own_ar_valid;
    logic   own_r_ready;

    assign own_ar_valid = owner ? d_ar_valid_i : i_ar_valid_i;
    assign own_r_ready  = owner ? d_r_ready_i  : i_r_ready_i;

    // last resets to dcache so that the first tie goes to icache
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_nxt       = last;
        i_ar_ready_o   = 1'b0;
        i_r_valid_o    = 1'b0;
        i_r_data_o     = '0;
        i_r_resp_o     = 2'b00;
        d_ar_ready_o   = 1'b0;
        d_r_valid_o    = 1'b0;
        d_r_data_o     = '0;
        d_r_resp_o     = 2'b00;
        mem_ar_valid_o = 1'b0;
        mem_ar_addr_o  = '0;
        mem_r_ready_o  = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_ar_valid_i || d_ar_valid_i) begin
                    owner_nxt = (i_ar_valid_i && d_ar_valid_i) ? ~last : d_ar_valid_i;
                    state_nxt = S_AR;
                end
            end

            S_AR: begin
                mem_ar_valid_o = own_ar_valid;
                mem_ar_addr_o  = owner ? d_ar_addr_i : i_ar_addr_i;
                if (owner) begin
                    d_ar_ready_o = mem_ar_ready_i;
                end else begin
                    i_ar_ready_o = mem_ar_ready_i;
                end
                // a withdrawn request releases the port without touching fairness
                if (own_ar_valid && mem_ar_ready_i) begin
                    state_nxt = S_R;
                end else if (!own_ar_valid) begin
                    state_nxt = S_IDLE;
                end
            end

            S_R: begin
                mem_r_ready_o = own_r_ready;
                if (owner) begin
                    d_r_valid_o = mem_r_valid_i;
                    d_r_data_o  = mem_r_data_i;
                    d_r_resp_o  = mem_r_resp_i;
                end else begin
                    i_r_valid_o = mem_r_valid_i;
                    i_r_data_o  = mem_r_data_i;
                    i_r_resp_o  = mem_r_resp_i;
                end
                if (mem_r_valid_i && own_r_ready) begin
                    state_nxt = S_IDLE;
                    last_nxt  = owner;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050019_mem_rd_arbiter.sv
// tb_ysyx_22050019_mem_rd_arbiter: scoreboard bench with a behavioural memory
// responder; expected grants and read data are queued as requests are issued.
`default_nettype none

module tb_ysyx_22050019_mem_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          i_ar_valid, i_ar_ready_o, i_r_valid_o, i_r_ready;
    logic [AW-1:0] i_ar_addr;
    logic [DW-1:0] i_r_data_o;
    logic [1:0]    i_r_resp_o;
    logic          d_ar_valid, d_ar_ready_o, d_r_valid_o, d_r_ready;
    logic [AW-1:0] d_ar_addr;
    logic [DW-1:0] d_r_data_o;
    logic [1:0]    d_r_resp_o;
    logic          mem_ar_valid_o, mem_ar_ready, mem_r_valid, mem_r_ready_o;
    logic [AW-1:0] mem_ar_addr_o;
    logic [DW-1:0] mem_r_data;
    logic [1:0]    mem_r_resp;

    ysyx_22050019_mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ar_valid_i   (i_ar_valid),
        .i_ar_ready_o   (i_ar_ready_o),
        .i_ar_addr_i    (i_ar_addr),
        .i_r_valid_o    (i_r_valid_o),
        .i_r_ready_i    (i_r_ready),
        .i_r_data_o     (i_r_data_o),
        .i_r_resp_o     (i_r_resp_o),
        .d_ar_valid_i   (d_ar_valid),
        .d_ar_ready_o   (d_ar_ready_o),
        .d_ar_addr_i    (d_ar_addr),
        .d_r_valid_o    (d_r_valid_o),
        .d_r_ready_i    (d_r_ready),
        .d_r_data_o     (d_r_data_o),
        .d_r_resp_o     (d_r_resp_o),
        .mem_ar_valid_o (mem_ar_valid_o),
        .mem_ar_ready_i (mem_ar_ready),
        .mem_ar_addr_o  (mem_ar_addr_o),
        .mem_r_valid_i  (mem_r_valid),
        .mem_r_ready_o  (mem_r_ready_o),
        .mem_r_data_i   (mem_r_data),
        .mem_r_resp_i   (mem_r_resp)
    );

    int total = 0;
    int bad   = 0;

    logic [65:0] exp_i[$];
    logic [65:0] exp_d[$];
    logic        exp_grant[$];

    logic          ar_hs, r_hs, i_ar_hs, d_ar_hs, i_r_hs, d_r_hs;
    logic [AW-1:0] lat_addr;
    int            ar_stall;
    int            n;
    logic [9:0]    ctrl;

    assign ctrl = {i_ar_ready_o, i_r_valid_o, i_r_resp_o, d_ar_ready_o, d_r_valid_o,
                   d_r_resp_o, mem_ar_valid_o, mem_r_ready_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
        return {~a, a};
    endfunction

    function automatic logic [1:0] mresp(input logic [AW-1:0] a);
        return a[5:4];
    endfunction

    // Memory slave: ar_ready after ar_stall cycles of a pending request, one read beat next cycle.
    initial begin
        int stall;
        bit busy;
        mem_ar_ready = 1'b0;
        mem_r_valid  = 1'b0;
        mem_r_data   = '0;
        mem_r_resp   = 2'b00;
        stall        = 0;
        busy         = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ar_ready = 1'b0;
                mem_r_valid  = 1'b0;
                mem_r_data   = '0;
                mem_r_resp   = 2'b00;
                stall        = 0;
                busy         = 1'b0;
            end else if (!busy) begin
                if (ar_hs) begin
                    mem_ar_ready = 1'b0;
                    mem_r_valid  = 1'b1;
                    mem_r_data   = mdata(lat_addr);
                    mem_r_resp   = mresp(lat_addr);
                    busy         = 1'b1;
                    stall        = 0;
                end else if (mem_ar_valid_o && !mem_ar_ready) begin
                    if (stall < ar_stall) stall++;
                    else mem_ar_ready = 1'b1;
                end else if (!mem_ar_valid_o) begin
                    mem_ar_ready = 1'b0;
                end
            end else if (r_hs) begin
                mem_r_valid = 1'b0;
                mem_r_data  = '0;
                mem_r_resp  = 2'b00;
                busy        = 1'b0;
            end
        end
    end

    // Monitor just before each rising edge: predicts handshakes, pops the scoreboard.
    initial begin
        logic [65:0] e;
        {ar_hs, r_hs, i_ar_hs, d_ar_hs, i_r_hs, d_r_hs} = '0;
        lat_addr = '0;
        forever begin
            @(negedge clk);
            #4;
            ar_hs   = rst_n && mem_ar_valid_o && mem_ar_ready;
            r_hs    = rst_n && mem_r_valid && mem_r_ready_o;
            i_ar_hs = rst_n && i_ar_valid && i_ar_ready_o;
            d_ar_hs = rst_n && d_ar_valid && d_ar_ready_o;
            i_r_hs  = rst_n && i_r_valid_o && i_r_ready;
            d_r_hs  = rst_n && d_r_valid_o && d_r_ready;
            if (ar_hs) begin
                lat_addr = mem_ar_addr_o;
                if (exp_grant.size() == 0) check("grant_unexpected", 1, 0);
                else check("grant_owner", {63'b0, d_ar_ready_o}, {63'b0, exp_grant.pop_front()});
            end
            if (i_r_hs) begin
                if (exp_i.size() == 0) check("i_r_unexpected", 1, 0);
                else begin
                    e = exp_i.pop_front();
                    check("i_r_data", i_r_data_o, e[63:0]);
                    check("i_r_resp", {62'b0, i_r_resp_o}, {62'b0, e[65:64]});
                end
            end
            if (d_r_hs) begin
                if (exp_d.size() == 0) check("d_r_unexpected", 1, 0);
                else begin
                    e = exp_d.pop_front();
                    check("d_r_data", d_r_data_o, e[63:0]);
                    check("d_r_resp", {62'b0, d_r_resp_o}, {62'b0, e[65:64]});
                end
            end
            if (i_r_valid_o)
                check("d_quiet_while_i", {d_r_data_o | {62'b0, d_r_resp_o}} | {63'b0, d_r_valid_o}, 0);
            if (d_r_valid_o)
                check("i_quiet_while_d", {i_r_data_o | {62'b0, i_r_resp_o}} | {63'b0, i_r_valid_o}, 0);
            if (!i_r_valid_o && !d_r_valid_o)
                check("rdata_zero_no_valid", i_r_data_o | d_r_data_o, 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the read-data handshake.
    task automatic do_read(input bit m, input logic [AW-1:0] a, input int rdly);
        int k;
        if (m) begin
            exp_d.push_back({mresp(a), mdata(a)});
            d_ar_valid = 1'b1;
            d_ar_addr  = a;
        end else begin
            exp_i.push_back({mresp(a), mdata(a)});
            i_ar_valid = 1'b1;
            i_ar_addr  = a;
        end
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(m ? d_ar_hs : i_ar_hs) && k < 100);
        if (k >= 100) check("ar_timeout", 0, 1);
        if (m) begin d_ar_valid = 1'b0; d_ar_addr = '0; end
        else   begin i_ar_valid = 1'b0; i_ar_addr = '0; end
        if (rdly > 0) begin
            k = 0;
            do begin @(posedge clk); #1; k++; end while (!(m ? d_r_valid_o : i_r_valid_o) && k < 100);
            if (k >= 100) check("rvalid_timeout", 0, 1);
            for (int j = 0; j < rdly; j++) begin
                check("rstall_mem_r_ready", {63'b0, mem_r_ready_o}, 0);
                check("rstall_r_valid_held", {63'b0, m ? d_r_valid_o : i_r_valid_o}, 1);
                @(posedge clk); #1;
            end
        end
        if (m) d_r_ready = 1'b1;
        else   i_r_ready = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(m ? d_r_hs : i_r_hs) && k < 100);
        if (k >= 100) check("r_timeout", 0, 1);
        if (m) d_r_ready = 1'b0;
        else   i_r_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {i_ar_valid, i_r_ready, d_ar_valid, d_r_ready} = '0;
        i_ar_addr = '0;
        d_ar_addr = '0;
        ar_stall  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {54'b0, ctrl}, 0);
        check("rst_data", i_r_data_o | d_r_data_o, 0);
        check("rst_addr", {32'b0, mem_ar_addr_o}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ctrl", {54'b0, ctrl}, 0);

        // icache alone: one-cycle request latency, fixed data word
        exp_grant.push_back(1'b0);
        fork
            do_read(1'b0, 32'h8000_0000, 0);
            begin
                check("lat_c0_valid", {63'b0, mem_ar_valid_o}, 0);
                @(posedge clk); #1;
                check("lat_c1_valid", {63'b0, mem_ar_valid_o}, 1);
                check("lat_c1_addr", {32'b0, mem_ar_addr_o}, 64'h8000_0000);
                check("lat_c1_d_side", {62'b0, d_ar_ready_o, d_r_valid_o}, 0);
            end
        join

        // tie after an icache completion: dcache goes first
        exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0);
        fork
            do_read(1'b0, 32'h0000_0100, 0);
            do_read(1'b1, 32'h0000_0200, 0);
        join

        // fresh reset: icache wins the first tie, and again on the third
        reset_pulse();
        repeat (2) begin
            exp_grant.push_back(1'b0);
            exp_grant.push_back(1'b1);
            fork
                do_read(1'b0, 32'h0000_0300, 0);
                do_read(1'b1, 32'h0000_0340, 0);
            join
        end

        // dcache stalled on AR for 5 cycles; icache arrives meanwhile and is held off
        ar_stall = 5;
        exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0);
        fork
            do_read(1'b1, 32'h0000_1040, 0);
            begin
                n = 0;
                do begin @(negedge clk); #1; n++; end while (!mem_ar_valid_o && n < 50);
                for (int k = 0; k < 5; k++) begin
                    check("stall_d_ar_ready", {63'b0, d_ar_ready_o}, 0);
                    check("stall_addr", {32'b0, mem_ar_addr_o}, 64'h1040);
                    check("stall_i_ar_ready", {63'b0, i_ar_ready_o}, 0);
                    @(negedge clk); #1;
                end
                ar_stall = 0;
            end
            begin
                n = 0;
                do begin @(posedge clk); #1; n++; end while (!mem_ar_valid_o && n < 50);
                do_read(1'b0, 32'h0000_2000, 0);
            end
        join

        // error responses pass through, no retry
        exp_grant.push_back(1'b1);
        do_read(1'b1, 32'h0000_0120, 0);
        check("slverr_no_retry_a", {63'b0, mem_ar_valid_o}, 0);
        @(posedge clk); #1;
        check("slverr_no_retry_b", {63'b0, mem_ar_valid_o}, 0);
        exp_grant.push_back(1'b0);
        do_read(1'b0, 32'h0000_0330, 0);

        // icache holds r_ready low for 3 cycles
        exp_grant.push_back(1'b0);
        do_read(1'b0, 32'h0000_0400, 3);

        // reset in S_R with memory data valid
        exp_grant.push_back(1'b0);
        i_ar_valid = 1'b1;
        i_ar_addr  = 32'h0000_0600;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!i_ar_hs && n < 50);
        if (n >= 50) check("rst_test_ar_timeout", 0, 1);
        i_ar_valid = 1'b0;
        i_ar_addr  = '0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!mem_r_valid && n < 50);
        check("pre_rst_i_r_valid", {63'b0, i_r_valid_o}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", {54'b0, ctrl}, 0);
        check("async_rst_data", i_r_data_o | d_r_data_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_r_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("no_r_valid_after_rst", {63'b0, i_r_valid_o}, 0);
        i_r_ready = 1'b0;

        // after release arbitration restarts cleanly
        exp_grant.push_back(1'b1);
        do_read(1'b1, 32'h0000_0510, 0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_i.size() + exp_d.size() + exp_grant.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22050019_mem_rd_arbiter.md
YSYX_22050019_MEM_RD_ARBITER -- requirements
Module: ysyx_22050019_mem_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on all AR channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width on all R channels.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ar_valid_i  in  1  icache read request valid.
REQ-006 SHALL have port i_ar_ready_o  out  1  icache request accepted.
REQ-007 SHALL have port i_ar_addr_i  in  ADDR_WIDTH  icache line address.
REQ-008 SHALL have port i_r_valid_o  out  1  icache read data valid.
REQ-009 SHALL have port i_r_ready_i  in  1  icache ready for data.
REQ-010 SHALL have port i_r_data_o  out  DATA_WIDTH  icache read data.
REQ-011 SHALL have port i_r_resp_o  out  2  icache read response.
REQ-012 SHALL have ports d_ar_valid_i, d_ar_ready_o, d_ar_addr_i, d_r_valid_o, d_r_ready_i, d_r_data_o, d_r_resp_o with the same direction, width and meaning for the dcache master.
REQ-013 SHALL have ports mem_ar_valid_o out 1, mem_ar_ready_i in 1, mem_ar_addr_o out ADDR_WIDTH, mem_r_valid_i in 1, mem_r_ready_o out 1, mem_r_data_i in DATA_WIDTH, mem_r_resp_i in 2: shared memory read port.

Function
REQ-014 SHALL arbitrate single-beat reads from icache and dcache onto one memory read port; one transaction outstanding at a time.
REQ-015 SHALL implement states S_IDLE, S_AR, S_R, plus owner bit (0=icache, 1=dcache) and round-robin pointer last (owner of last completed transaction).
REQ-016 S_IDLE: all ar_ready, r_valid, mem_ar_valid, mem_r_ready SHALL be 0; if any ar_valid is 1, owner SHALL be latched and state SHALL go to S_AR next cycle.
REQ-017 Owner selection: only one valid -> that master; both valid -> master != last (round-robin).
REQ-018 S_AR: mem_ar_valid_o = owner ar_valid, mem_ar_addr_o = owner ar_addr, owner ar_ready = mem_ar_ready_i, combinational; non-owner ar_ready SHALL be 0.
REQ-019 S_AR: on mem_ar_valid_o & mem_ar_ready_i -> S_R; if owner drops ar_valid before handshake -> S_IDLE, last unchanged.
REQ-020 S_R: owner r_valid/r_data/r_resp = mem_r_valid_i/mem_r_data_i/mem_r_resp_i; mem_r_ready_o = owner r_ready; non-owner r_valid 0, r_data 0, r_resp 0.
REQ-021 S_R: on mem_r_valid_i & mem_r_ready_o -> S_IDLE and last <= owner, same edge.
REQ-022 Outside S_AR, mem_ar_addr_o SHALL be 0; outside S_R, all r_data/r_resp outputs SHALL be 0.
REQ-023 Minimum latency: ar_valid at cycle 0 -> mem_ar_valid_o at cycle 1; back-to-back transactions separated by one S_IDLE cycle.
REQ-024 Responses (incl. SLVERR/DECERR) SHALL pass through unmodified; arbiter SHALL not retry.
REQ-025 Requests arriving in S_AR/S_R from the non-owner SHALL be held off (ar_ready 0) and considered in the next S_IDLE.

Reset
REQ-026 rst_n low SHALL immediately force S_IDLE, owner=0, last=1 (icache wins first tie), all outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it without emitting r_valid; after release, arbitration restarts from S_IDLE.

Verification
REQ-028 icache only, addr 0x8000_0000, mem ready immediately, data 0x1122334455667788 -> mem_ar_valid cycle 1, i_r_data 0x1122334455667788 with resp 0, d_* outputs stay 0.
REQ-029 Both request same cycle after reset -> icache granted first, dcache granted on the S_IDLE after icache's R handshake; third tie -> icache again.
REQ-030 dcache granted, mem_ar_ready held 0 for 5 cycles -> d_ar_ready 0 for 5 cycles, mem_ar_addr stable, i_ar_ready 0 throughout.
REQ-031 mem_r_resp 2'b10 on dcache read -> d_r_resp 2'b10, state returns to S_IDLE, no retry.
REQ-032 rst_n asserted in S_R with mem_r_valid 1 -> all outputs 0 asynchronously, no r_valid to owner; next request after release proceeds normally.
REQ-033 i_r_ready held 0 for 3 cycles while mem_r_valid 1 -> mem_r_ready 0, state stays S_R until i_r_ready rises.
